resonator_dds_div_34s_16ns_18_seq: RTL and testbench



---
 rtl/resonator_dds_div_34s_16ns_18_seq_if.sv | 26 ++
 rtl/resonator_dds_div_34s_16ns_18_seq.sv | 176 +++++++++++++++++
 tb/tb_resonator_dds_div_34s_16ns_18_seq.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/resonator_dds_div_34s_16ns_18_seq_if.sv
// Start/done handshake bundle for the resonator_dds sequential divider.
interface resonator_dds_div_34s_16ns_18_seq_if #(
    parameter int unsigned DIVIDEND_WIDTH = 34,
    parameter int unsigned DIVISOR_WIDTH  = 16,
    parameter int unsigned QUOTIENT_WIDTH = 18
);
    logic                             start;
    logic signed [DIVIDEND_WIDTH-1:0] din0;
    logic        [DIVISOR_WIDTH-1:0]  din1;
    logic                             ready;
    logic                             done;
    logic signed [QUOTIENT_WIDTH-1:0] dout;
    logic signed [DIVISOR_WIDTH:0]    rem;
    logic                             ovf;
    logic                             div0;

    modport master (
        output start, din0, din1,
        input  ready, done, dout, rem, ovf, div0
    );

    modport slave (
        input  start, din0, din1,
        output ready, done, dout, rem, ovf, div0
    );
endinterface

// File: rtl/resonator_dds_div_34s_16ns_18_seq.sv
// Restoring radix-2 divider: signed 34b / unsigned 16b -> saturated signed 18b quotient, 35-cycle
// fixed latency. Define RESONATOR_DDS_DIV_ROUND_EN for round-half-away-from-zero quotients.
module resonator_dds_div_34s_16ns_18_seq #(
    parameter int unsigned DIVIDEND_WIDTH = 34,
    parameter int unsigned DIVISOR_WIDTH  = 16,
    parameter int unsigned QUOTIENT_WIDTH = 18
) (
    input logic clk,
    input logic reset,
    input logic ce,
    resonator_dds_div_34s_16ns_18_seq_if.slave bus
);
    localparam int unsigned RW = DIVISOR_WIDTH + 1;
    localparam int unsigned MW = DIVIDEND_WIDTH + 1;
    localparam int unsigned CW = $clog2(DIVIDEND_WIDTH + 1);

    localparam logic [MW-1:0] PosLim = MW'((64'd1 << (QUOTIENT_WIDTH - 1)) - 64'd1);
    localparam logic [MW-1:0] NegLim = MW'(64'd1 << (QUOTIENT_WIDTH - 1));
    localparam logic signed [QUOTIENT_WIDTH-1:0] QMax = {1'b0, {(QUOTIENT_WIDTH-1){1'b1}}};
    localparam logic signed [QUOTIENT_WIDTH-1:0] QMin = {1'b1, {(QUOTIENT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

    state_e state_q, state_d;

    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      neg_q, neg_d;
    logic [DIVIDEND_WIDTH-1:0] quo_q, quo_d;
    logic [DIVISOR_WIDTH-1:0]  dvs_q, dvs_d;
    logic [RW-1:0]             prem_q, prem_d;

    logic                             done_q, done_d;
    logic signed [QUOTIENT_WIDTH-1:0] dout_q, dout_d;
    logic signed [RW-1:0]             rem_q, rem_d;
    logic                             ovf_q, ovf_d;
    logic                             div0_q, div0_d;

    logic [RW-1:0]                    shifted;
    logic                             qbit;
    logic                             round_inc;
    logic [MW-1:0]                    mag;
    logic signed [QUOTIENT_WIDTH-1:0] q_sat;
    logic                             q_ovf;
    logic signed [RW-1:0]             rem_sgn;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else if (ce) begin
            state_q <= state_d;
        end
    end

    // FSM: next state (ce gating lives in the registers)
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StCalc;
            StCalc:  if (cnt_q == CW'(DIVIDEND_WIDTH - 1)) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.ready = (state_q == StIdle);
        bus.done  = done_q;
        bus.dout  = dout_q;
        bus.rem   = rem_q;
        bus.ovf   = ovf_q;
        bus.div0  = div0_q;
    end

    // Sign application and saturation of the finished magnitude
    always_comb begin
`ifdef RESONATOR_DDS_DIV_ROUND_EN
        round_inc = (dvs_q != '0) && ({prem_q, 1'b0} >= {2'b00, dvs_q});
`else
        round_inc = 1'b0;
`endif
        mag   = {1'b0, quo_q} + MW'(round_inc);
        q_ovf = 1'b0;
        if (dvs_q == '0) begin
            q_sat = neg_q ? QMin : QMax;
        end else if (neg_q) begin
            if (mag > NegLim) begin
                q_sat = QMin;
                q_ovf = 1'b1;
            end else begin
                q_sat = -$signed(mag[QUOTIENT_WIDTH-1:0]);
            end
        end else begin
            if (mag > PosLim) begin
                q_sat = QMax;
                q_ovf = 1'b1;
            end else begin
                q_sat = $signed(mag[QUOTIENT_WIDTH-1:0]);
            end
        end
        if (dvs_q == '0) begin
            rem_sgn = '0;
        end else if (neg_q) begin
            rem_sgn = -$signed(prem_q);
        end else begin
            rem_sgn = $signed(prem_q);
        end
    end

    // Datapath next state; quo_q shifts dividend bits out and quotient bits in
    always_comb begin
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        done_d  = 1'b0;
        dout_d  = dout_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        div0_d  = div0_q;
        shifted = {prem_q[RW-2:0], quo_q[DIVIDEND_WIDTH-1]};
        qbit    = (shifted >= {1'b0, dvs_q});
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    neg_d  = bus.din0[DIVIDEND_WIDTH-1];
                    quo_d  = bus.din0[DIVIDEND_WIDTH-1] ? -bus.din0 : bus.din0;
                    dvs_d  = bus.din1;
                    prem_d = '0;
                    cnt_d  = '0;
                end
            end
            StCalc: begin
                prem_d = qbit ? (shifted - {1'b0, dvs_q}) : shifted;
                quo_d  = {quo_q[DIVIDEND_WIDTH-2:0], qbit};
                cnt_d  = cnt_q + CW'(1);
            end
            StFin: begin
                done_d = 1'b1;
                dout_d = q_sat;
                rem_d  = rem_sgn;
                ovf_d  = q_ovf;
                div0_d = (dvs_q == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            neg_q  <= 1'b0;
            quo_q  <= '0;
            dvs_q  <= '0;
            prem_q <= '0;
            done_q <= 1'b0;
            dout_q <= '0;
            rem_q  <= '0;
            ovf_q  <= 1'b0;
            div0_q <= 1'b0;
        end else if (ce) begin
            cnt_q  <= cnt_d;
            neg_q  <= neg_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            prem_q <= prem_d;
            done_q <= done_d;
            dout_q <= dout_d;
            rem_q  <= rem_d;
            ovf_q  <= ovf_d;
            div0_q <= div0_d;
        end
    end
endmodule

// File: tb/tb_resonator_dds_div_34s_16ns_18_seq.sv
// Scoreboard bench for the sequential divider: driver queues expectations, monitor checks on done.
module tb_resonator_dds_div_34s_16ns_18_seq;
    logic clk = 1'b0;
    logic reset;
    logic ce;

    resonator_dds_div_34s_16ns_18_seq_if #(
        .DIVIDEND_WIDTH(34), .DIVISOR_WIDTH(16), .QUOTIENT_WIDTH(18)
    ) bus ();

    resonator_dds_div_34s_16ns_18_seq dut (
        .clk  (clk),
        .reset(reset),
        .ce   (ce),
        .bus  (bus)
    );

    always #5 clk = ~clk;

`ifdef RESONATOR_DDS_DIV_ROUND_EN
    localparam bit Rnd = 1'b1;
`else
    localparam bit Rnd = 1'b0;
`endif

    typedef struct {
        logic signed [33:0] a;
        logic [15:0]        b;
        int                 q;
        int                 qr;
        int                 r;
        bit                 ovf;
        bit                 ovfr;
        bit                 d0;
    } vec_t;

    typedef struct {
        int     id;
        int     q;
        int     r;
        bit     ovf;
        bit     d0;
        longint done_cyc;
    } exp_t;

    vec_t   vecs[12];
    exp_t   exp_q[$];
    int     tests = 0;
    int     fails = 0;
    longint cyc = 0;
    logic   ce_seen = 1'b0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        ce_seen <= ce;
    end

    task automatic chk(input string name, input int id, input longint got, input longint expv);
        tests++;
        if (got != expv) begin
            fails++;
            $display("FAIL %s (op %0d): got %0d, expected %0d", name, id, got, expv);
        end
    endtask

    // Monitor: one result per done edge taken with ce=1
    always @(negedge clk) begin
        if (!reset && bus.done && ce_seen) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("dout", e.id, longint'(bus.dout), longint'(e.q));
                chk("rem", e.id, longint'(bus.rem), longint'(e.r));
                chk("ovf", e.id, longint'(bus.ovf), longint'(e.ovf));
                chk("div0", e.id, longint'(bus.div0), longint'(e.d0));
                chk("latency", e.id, cyc, e.done_cyc);
            end
        end
    end

    function automatic exp_t mk_exp(input int i, input longint done_cyc);
        exp_t e;
        e.id       = i;
        e.q        = Rnd ? vecs[i].qr : vecs[i].q;
        e.r        = vecs[i].r;
        e.ovf      = Rnd ? vecs[i].ovfr : vecs[i].ovf;
        e.d0       = vecs[i].d0;
        e.done_cyc = done_cyc;
        return e;
    endfunction

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    // Issue vector i; optionally drop ce for 'stall' cycles during CALC
    task automatic run_vec(input int i, input int stall);
        @(negedge clk);
        bus.start = 1'b1;
        bus.din0  = vecs[i].a;
        bus.din1  = vecs[i].b;
        exp_q.push_back(mk_exp(i, cyc + 1 + 35 + stall));
        @(negedge clk);
        bus.start = 1'b0;
        bus.din0  = 34'h1_5555_5555;
        bus.din1  = 16'hA5A5;
        if (stall > 0) begin
            repeat (4) @(negedge clk);
            ce = 1'b0;
            repeat (stall) @(negedge clk);
            ce = 1'b1;
        end
        drain();
    endtask

    initial begin
        // id: dividend, divisor, q, q(round), rem, ovf, ovf(round), div0
        vecs[0]  = '{34'sd1000,       16'd7,     142,     143,     6,      0, 0, 0};
        vecs[1]  = '{-34'sd1000,      16'd7,     -142,    -143,    -6,     0, 0, 0};
        vecs[2]  = '{-34'sd131072,    16'd1,     -131072, -131072, 0,      0, 0, 0};
        vecs[3]  = '{34'sd2147483648, 16'd1,     131071,  131071,  0,      1, 1, 0};
        vecs[4]  = '{34'h2_0000_0000, 16'd1,     -131072, -131072, 0,      1, 1, 0};
        vecs[5]  = '{34'sd262143,     16'd2,     131071,  131071,  1,      0, 1, 0};
        vecs[6]  = '{34'sd5,          16'd0,     131071,  131071,  0,      0, 0, 1};
        vecs[7]  = '{-34'sd5,         16'd0,     -131072, -131072, 0,      0, 0, 1};
        vecs[8]  = '{34'sd1234567,    16'd65535, 18,      19,      54937,  0, 0, 0};
        vecs[9]  = '{-34'sd1234567,   16'd65535, -18,     -19,     -54937, 0, 0, 0};
        vecs[10] = '{34'sd100,        16'd3,     33,      33,      1,      0, 0, 0};
        vecs[11] = '{34'sd7,          16'd7,     1,       1,       0,      0, 0, 0};

        reset     = 1'b1;
        ce        = 1'b1;
        bus.start = 1'b1;
        bus.din0  = 34'sd99;
        bus.din1  = 16'd9;
        repeat (3) @(negedge clk);
        chk("rst_ready", -1, longint'(bus.ready), 1);
        chk("rst_done", -1, longint'(bus.done), 0);
        chk("rst_dout", -1, longint'(bus.dout), 0);
        chk("rst_rem", -1, longint'(bus.rem), 0);
        chk("rst_ovf", -1, longint'(bus.ovf), 0);
        chk("rst_div0", -1, longint'(bus.div0), 0);
        bus.start = 1'b0;
        reset     = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(i, 0);

        // start held high: second op may only be taken on the done cycle
        @(negedge clk);
        bus.start = 1'b1;
        bus.din0  = vecs[10].a;
        bus.din1  = vecs[10].b;
        exp_q.push_back(mk_exp(10, cyc + 1 + 35));
        exp_q.push_back(mk_exp(11, cyc + 1 + 36 + 35));
        @(negedge clk);
        bus.din0 = vecs[11].a;
        bus.din1 = vecs[11].b;
        repeat (36) @(negedge clk);
        bus.start = 1'b0;
        drain();

        run_vec(0, 10);

        // Reset mid-CALC aborts the op without a done pulse
        @(negedge clk);
        bus.start = 1'b1;
        bus.din0  = vecs[8].a;
        bus.din1  = vecs[8].b;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ready", -1, longint'(bus.ready), 1);
        chk("abort_done", -1, longint'(bus.done), 0);
        chk("abort_dout", -1, longint'(bus.dout), 0);
        chk("abort_rem", -1, longint'(bus.rem), 0);
        chk("abort_ovf", -1, longint'(bus.ovf), 0);
        repeat (40) @(negedge clk);
        run_vec(1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected earlier finish");
        $fatal(1, "watchdog");
    end
endmodule
